dpram_fifo_ctrl: RTL
====================

DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 The parameters SHALL be:
- ADDR_SIZE, default 4, RAM address width.
- DATA_SIZE, default 8, data width (informational only; no data path in this block).
- DEPTH, default 16, entries; SHALL equal 2**ADDR_SIZE.
- AF_LEVEL, default 14, almost-full threshold.
- AE_LEVEL, default 2, almost-empty threshold.

REQ-002 The ports SHALL be:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  write request from producer.
- pop  input  1  read request from consumer.
- cs  output  1  RAM chip select.
- we  output  1  RAM write enable.
- re  output  1  RAM read enable.
- oe  output  1  RAM output enable.
- wr_address  output  ADDR_SIZE  RAM write address.
- rd_address  output  ADDR_SIZE  RAM read address.
- rd_valid  output  1  RAM data_out holds popped word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse on rejected push.
- underflow  output  1  one-cycle pulse on rejected pop.

REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low (clk, rst_n).

Function
REQ-004 A push SHALL be accepted (wr_acc) when push=1 and full=0, and SHALL be rejected otherwise; a pop SHALL be accepted (rd_acc) when pop=1 and empty=0, and SHALL be rejected otherwise.
REQ-005 we SHALL equal wr_acc combinationally, and wr_address SHALL equal the registered write pointer, so the RAM writes at the same edge where the pointer advances.
REQ-006 re and oe SHALL both equal rd_acc combinationally, and rd_address SHALL equal the registered read pointer.
REQ-007 cs SHALL equal we OR re.
REQ-008 All of cs, we, re and oe SHALL be 0 whenever rst_n=0.
REQ-009 The write pointer SHALL increment by 1 on each wr_acc edge, and the read pointer SHALL increment by 1 on each rd_acc edge.
REQ-010 Both pointers SHALL wrap modulo DEPTH (DEPTH-1 -> 0) with no other effect.
REQ-011 count SHALL update as follows:
- +1 on wr_acc only.
- -1 on rd_acc only.
- unchanged when both or neither are accepted.
REQ-012 count SHALL never exceed DEPTH and SHALL never go below 0.
REQ-013 Simultaneous push and pop while empty SHALL accept the push only; no bypass; count -> 1.
REQ-014 Simultaneous push and pop while full SHALL accept the pop only; count -> DEPTH-1.
REQ-015 Simultaneous push and pop at 0 < count < DEPTH SHALL accept both and leave count unchanged.
REQ-016 full, empty, almost_full and almost_empty SHALL be combinational decodes of the registered count.
REQ-017 rd_valid SHALL be registered and SHALL equal rd_acc delayed by exactly one cycle, matching the RAM's one-cycle registered read latency.
REQ-018 overflow SHALL be registered, =1 for exactly the cycle after push=1 while full=1, otherwise 0.
REQ-019 underflow SHALL be registered, =1 for exactly the cycle after pop=1 while empty=1, otherwise 0.
REQ-020 A rejected request SHALL NOT change pointers, count or RAM contents.

Reset
REQ-021 While rst_n=0, the block SHALL hold:
- write and read pointers = 0, wr_address = 0, rd_address = 0.
- count = 0, empty = 1, almost_empty = 1.
- full = 0, almost_full = 0.
- rd_valid = 0, overflow = 0, underflow = 0.
- cs = we = re = oe = 0.
REQ-022 Reset asserted mid-operation SHALL clear all state immediately, without waiting for a clock edge, and any pending rd_valid SHALL be dropped.
REQ-023 After rst_n deasserts, the first push SHALL be accepted on the first rising edge and SHALL write address 0.

Verification
REQ-024 Fill: 16 consecutive pushes from reset -> wr_address 0..15, we=1 each cycle, count 16, full=1, almost_full=1 from count 14 on, no overflow.
REQ-025 Drain: 16 consecutive pops from full -> rd_address 0..15, re=oe=1, rd_valid one cycle later each, empty=1 at end, almost_empty=1 from count 2 on.
REQ-026 Error pulses:
- push at full -> overflow=1 for one cycle; count stays 16; we=0.
- pop at empty -> underflow=1 for one cycle; re=0.
REQ-027 Simultaneous push and pop:
- at count 5 -> count stays 5, both pointers advance.
- at count 0 -> push only, count 1, rd_valid stays 0.
- at count 16 -> pop only, count 15.
REQ-028 Wrap: 20 pushes interleaved with 20 pops, count staying at or below 4 -> pointers wrap 15 -> 0, count never exceeds 4, no overflow or underflow.
REQ-029 Reset mid-stream: rst_n=0 at count 7 with a pop in flight -> count 0, rd_valid 0, empty 1 within the same cycle, without a clock edge.

Source files
------------

// File: rtl/dpram_fifo_ctrl.sv
// Control and status logic for a FIFO built around an external dual-port RAM.
// It produces RAM strobes and addresses, occupancy flags and error pulses; no data path.
module dpram_fifo_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16,
    parameter int AF_LEVEL  = 14,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    output logic                 cs,
    output logic                 we,
    output logic                 re,
    output logic                 oe,
    output logic [ADDR_SIZE-1:0] wr_address,
    output logic [ADDR_SIZE-1:0] rd_address,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE+1)'(AF_LEVEL);
    localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE+1)'(AE_LEVEL);
    localparam bit CFG_OK = (DEPTH == (1 << ADDR_SIZE)) && (DATA_SIZE > 0);

    // Pointers wrap for free only when DEPTH is a power of two matching the address width.
    if (!CFG_OK) begin : g_bad_cfg
        $error("dpram_fifo_ctrl: DEPTH must equal 2**ADDR_SIZE and DATA_SIZE must be positive");
    end

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 wr_acc, rd_acc;

    // Flags decode straight from the registered count.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    assign wr_acc = push & ~full;
    assign rd_acc = pop & ~empty;

    // Strobes are gated by rst_n so a request held during reset never reaches the RAM.
    assign we = wr_acc & rst_n;
    assign re = rd_acc & rst_n;
    assign oe = rd_acc & rst_n;
    assign cs = we | re;

    assign wr_address = wr_ptr_q;
    assign rd_address = rd_ptr_q;
    assign count      = count_q;
    assign rd_valid   = rd_valid_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = rd_acc;
        overflow_d  = push & full;
        underflow_d = pop & empty;

        if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_SIZE+1)'(1);
            2'b01:   count_d = count_q - (ADDR_SIZE+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
